// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares the single UART transmit path among N
//   byte-stream requesters. A requester owns the line for a whole packet.
//   Writes into the UART TX FIFO are paced BYTE_GAP clocks apart because the
//   FIFO has no full flag.
//
// Ports
//   CLK_50MHZ : sole clock, rising edge
//   RST       : synchronous active-high reset
//   REQ[N]    : requester i wants to send; held high for the whole packet
//   DATA[8N]  : byte offered by requester i at [8i+7:8i]
//   LAST[N]   : offered byte of requester i is the last of its packet
//   GRANT[N]  : one-hot current owner, zero when idle
//   ACK[N]    : one-cycle pulse, requester i's current byte was taken
//   TX_DATA   : drives UART DATA_IN
//   TX_WRITE  : one-cycle pulse, drives UART TRG_WRITE
//   BUSY      : high whenever the arbiter is not idle
module uart_tx_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned BYTE_GAP = 5000,
  parameter int unsigned GAP_W    = 13
) (
  input  logic           CLK_50MHZ,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [8*N-1:0] DATA,
  input  logic [N-1:0]   LAST,
  output logic [N-1:0]   GRANT,
  output logic [N-1:0]   ACK,
  output logic [7:0]     TX_DATA,
  output logic           TX_WRITE,
  output logic           BUSY
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_f;

  // Round-robin search: first set REQ bit at or above ptr, wrapping to 0.
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [N-1:0]     win_onehot;
  int unsigned      idx;

  always_comb begin
    found      = 1'b0;
    winner     = '0;
    win_onehot = '0;
    idx        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = k + 32'(ptr);
      if (idx >= N) idx = idx - N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && (idx == j) && REQ[j]) begin
          found  = 1'b1;
          winner = PTR_W'(j);
        end
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      win_onehot[j] = found && (winner == PTR_W'(j));
    end
  end

  // Owner's byte, LAST and REQ, selected with constant indices.
  logic [7:0] owner_data;
  logic       owner_last;
  logic       owner_req;

  always_comb begin
    owner_data = '0;
    owner_last = 1'b0;
    owner_req  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (owner == PTR_W'(j)) begin
        owner_data = DATA[8*j +: 8];
        owner_last = LAST[j];
        owner_req  = REQ[j];
      end
    end
  end

  logic [PTR_W-1:0] next_ptr;
  assign next_ptr = (owner == PTR_W'(N - 1)) ? '0 : owner + PTR_W'(1);

  // The counter is loaded with BYTE_GAP-2 so that GAP lasts BYTE_GAP-1 cycles;
  // together with the one-cycle SEND this spaces TX_WRITE pulses by BYTE_GAP.
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state    <= IDLE;
      GRANT    <= '0;
      ACK      <= '0;
      TX_DATA  <= '0;
      TX_WRITE <= 1'b0;
      BUSY     <= 1'b0;
      ptr      <= '0;
      owner    <= '0;
      gap_cnt  <= '0;
      last_f   <= 1'b0;
    end else begin
      ACK      <= '0;
      TX_WRITE <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= winner;
            GRANT <= win_onehot;
            BUSY  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          TX_DATA  <= owner_data;
          TX_WRITE <= 1'b1;
          ACK      <= GRANT;
          last_f   <= owner_last;
          gap_cnt  <= GAP_W'(BYTE_GAP - 2);
          state    <= GAP;
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (last_f || !owner_req) begin
              GRANT <= '0;
              ptr   <= next_ptr;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= SEND;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
